// File: rtl/rw_port_arbiter.sv
// rw_port_arbiter: round-robin share of one single-port RAM between two clients.
// Optional grant locking is enabled by defining MEM_ARB_LOCK_EN.
module rw_port_arbiter #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_wmode,
    input  logic              req0_lock,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_wmode,
    input  logic              req1_lock,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              mem_en,
    output logic              mem_wmode,
    output logic              mem_wmask,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    generate
        if ((1 << ADDR_W) < DEPTH) begin : g_bad_addr_w
            $error("ADDR_W too narrow for DEPTH");
        end
    endgenerate

    // 1 means requester 1 won the last accepted beat, so requester 0 wins a tie.
    logic last_grant;
    logic rr_grant0;
    logic rr_grant1;
    logic grant0;
    logic grant1;
    logic accept;
    logic sel;

`ifdef MEM_ARB_LOCK_EN
    logic locked;
    logic lock_owner;
`else
    logic unused_lock;
    assign unused_lock = req0_lock ^ req1_lock;
`endif

    // Plain round-robin choice; only valids of both sides feed it, never ready.
    always_comb begin
        rr_grant0 = 1'b0;
        rr_grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            rr_grant0 = last_grant;
            rr_grant1 = !last_grant;
        end else begin
            rr_grant0 = req0_valid;
            rr_grant1 = req1_valid;
        end
    end

    // Final grant: a held lock restricts the grant to its owner, idle or not.
    always_comb begin
        grant0 = rr_grant0;
        grant1 = rr_grant1;
`ifdef MEM_ARB_LOCK_EN
        if (locked) begin
            grant0 = !lock_owner && req0_valid;
            grant1 = lock_owner && req1_valid;
        end
`endif
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;
    assign sel        = grant1;

    // Drive the RAM port from the granted request, all zero when idle.
    always_comb begin
        mem_en    = 1'b0;
        mem_wmode = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (accept) begin
            mem_en = 1'b1;
            if (sel) begin
                mem_wmode = req1_wmode;
                mem_addr  = req1_addr;
                mem_wdata = req1_wdata;
            end else begin
                mem_wmode = req0_wmode;
                mem_addr  = req0_addr;
                mem_wdata = req0_wdata;
            end
        end
    end

    assign mem_wmask = mem_wmode;

    // Remember the winner of each accepted beat for the next tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= sel;
        end
    end

`ifdef MEM_ARB_LOCK_EN
    // Owner's accepted beat sets or clears the lock from its lock bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            locked     <= 1'b0;
            lock_owner <= 1'b0;
        end else if (accept) begin
            locked     <= sel ? req1_lock : req0_lock;
            lock_owner <= sel;
        end
    end
`endif

    // Requester 0 read response: capture RAM data, pulse rvalid once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req0_rvalid <= 1'b0;
            req0_rdata  <= '0;
        end else begin
            req0_rvalid <= grant0 && !req0_wmode;
            if (grant0 && !req0_wmode) begin
                req0_rdata <= mem_rdata;
            end
        end
    end

    // Requester 1 read response: capture RAM data, pulse rvalid once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req1_rvalid <= 1'b0;
            req1_rdata  <= '0;
        end else begin
            req1_rvalid <= grant1 && !req1_wmode;
            if (grant1 && !req1_wmode) begin
                req1_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_rw_port_arbiter.sv
// tb_rw_port_arbiter: directed vectors against rw_port_arbiter.
// Holds a behavioural RAM on the mem_* bus.
module tb_rw_port_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0;
    logic          req0_ready;
    logic          req0_wmode = 1'b0;
    logic          req0_lock = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req0_rvalid;
    logic [DW-1:0] req0_rdata;
    logic          req1_valid = 1'b0;
    logic          req1_ready;
    logic          req1_wmode = 1'b0;
    logic          req1_lock = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic          req1_rvalid;
    logic [DW-1:0] req1_rdata;
    logic          mem_en;
    logic          mem_wmode;
    logic          mem_wmask;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] ram [32];
    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    assign mem_rdata = ram[mem_addr];

    always @(posedge clock) begin
        if (mem_en && mem_wmode) ram[mem_addr] <= mem_wdata;
    end

    rw_port_arbiter #(.DEPTH(32), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_wmode(req0_wmode), .req0_lock(req0_lock),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_wmode(req1_wmode), .req1_lock(req1_lock),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .mem_en(mem_en), .mem_wmode(mem_wmode), .mem_wmask(mem_wmask),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_lock  = 1'b0;
        req1_lock  = 1'b0;
        req0_wmode = 1'b0;
        req1_wmode = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = 32'h1000_0000 + i;
        idle();
        do_reset();
        chk("rst_rvalid0", {31'd0, req0_rvalid}, 32'd0);
        chk("rst_rvalid1", {31'd0, req1_rvalid}, 32'd0);
        chk("rst_rdata0", req0_rdata, 32'd0);
        chk("rst_rdata1", req1_rdata, 32'd0);

        // write then read back through requester 0
        req0_valid = 1'b1; req0_wmode = 1'b1;
        req0_addr = 5'd3; req0_wdata = 32'hDEAD_BEEF;
        #1;
        chk("t1_wr_ready", {31'd0, req0_ready}, 32'd1);
        chk("t1_wr_en", {31'd0, mem_en}, 32'd1);
        chk("t1_wr_wmode", {31'd0, mem_wmode}, 32'd1);
        chk("t1_wr_wmask", {31'd0, mem_wmask}, 32'd1);
        chk("t1_wr_addr", {27'd0, mem_addr}, 32'd3);
        chk("t1_wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        chk("t1_wr_norsp", {31'd0, req0_rvalid}, 32'd0);
        req0_wmode = 1'b0;
        #1;
        chk("t1_rd_ready", {31'd0, req0_ready}, 32'd1);
        tick();
        idle();
        chk("t1_rvalid", {31'd0, req0_rvalid}, 32'd1);
        chk("t1_rdata", req0_rdata, 32'hDEAD_BEEF);
        tick();
        chk("t1_rvalid_off", {31'd0, req0_rvalid}, 32'd0);
        chk("t1_rdata_hold", req0_rdata, 32'hDEAD_BEEF);

        // both requesters reading continuously after reset
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd3;
        req1_valid = 1'b1; req1_addr = 5'd4;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("t2_ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t2_ready1", {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            chk("t2_rvalid0", {31'd0, req0_rvalid}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t2_rvalid1", {31'd0, req1_rvalid}, (i % 2 == 1) ? 32'd1 : 32'd0);
        end
        chk("t2_rdata0", req0_rdata, 32'hDEAD_BEEF);
        chk("t2_rdata1", req1_rdata, 32'h1000_0004);
        idle();
        tick();

        // requester 1 writes, requester 0 reads the same word next
        req1_valid = 1'b1; req1_wmode = 1'b1;
        req1_addr = 5'd7; req1_wdata = 32'h5;
        #1;
        chk("t3_wr_ready1", {31'd0, req1_ready}, 32'd1);
        tick();
        chk("t3_rvalid1_a", {31'd0, req1_rvalid}, 32'd0);
        idle();
        req0_valid = 1'b1; req0_addr = 5'd7;
        #1;
        chk("t3_rd_ready0", {31'd0, req0_ready}, 32'd1);
        tick();
        idle();
        chk("t3_rvalid0", {31'd0, req0_rvalid}, 32'd1);
        chk("t3_rdata0", req0_rdata, 32'h5);
        chk("t3_rvalid1_b", {31'd0, req1_rvalid}, 32'd0);
        tick();

        // reset lands while a read is being accepted
        req0_valid = 1'b1; req0_addr = 5'd2;
        #1;
        chk("t4_ready0", {31'd0, req0_ready}, 32'd1);
        #2;
        reset = 1'b1;
        tick();
        chk("t4_rvalid0", {31'd0, req0_rvalid}, 32'd0);
        chk("t4_rdata0", req0_rdata, 32'd0);
        reset = 1'b0;
        req1_valid = 1'b1; req1_addr = 5'd1;
        #1;
        chk("t4_tie_ready0", {31'd0, req0_ready}, 32'd1);
        chk("t4_tie_ready1", {31'd0, req1_ready}, 32'd0);
        tick();
        idle();
        tick();

`ifdef MEM_ARB_LOCK_EN
        // requester 1 holds the port for three beats
        req0_valid = 1'b1; req0_addr = 5'd3;
        tick();
        req1_valid = 1'b1; req1_addr = 5'd4;
        for (int i = 0; i < 3; i++) begin
            req1_lock = (i < 2);
            #1;
            chk("t5_lock_ready1", {31'd0, req1_ready}, 32'd1);
            chk("t5_lock_ready0", {31'd0, req0_ready}, 32'd0);
            tick();
        end
        req1_lock = 1'b0;
        #1;
        chk("t5_free_ready0", {31'd0, req0_ready}, 32'd1);
        chk("t5_free_ready1", {31'd0, req1_ready}, 32'd0);
        tick();
        idle();
        tick();
`endif

        // fully idle bus
        idle();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t6_en", {31'd0, mem_en}, 32'd0);
            chk("t6_wmode", {31'd0, mem_wmode}, 32'd0);
            chk("t6_wmask", {31'd0, mem_wmask}, 32'd0);
            chk("t6_addr", {27'd0, mem_addr}, 32'd0);
            chk("t6_wdata", mem_wdata, 32'd0);
            tick();
        end
        chk("t6_ram3", ram[3], 32'hDEAD_BEEF);
        chk("t6_ram7", ram[7], 32'h5);
        chk("t6_ram0", ram[0], 32'h1000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
